// File: rtl/tmds_channel_encoder.sv
// TMDS lane encoder: 8-bit pixel data or 2-bit control in, 10-bit symbol out.
// Two register stages: transition minimisation (XOR/XNOR chain), then DC
// balancing against a signed running-disparity counter. Fixed two-cycle
// latency, one symbol per clock, so the three colour lanes stay aligned.
module tmds_channel_encoder #(
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ve,
  input  logic [7:0]       i_data,
  input  logic [1:0]       i_ctrl,
  output logic [9:0]       o_tmds,
  output logic [CNT_W-1:0] o_disparity
);

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  localparam logic signed [CNT_W-1:0] ZERO = '0;
  localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  // ---------------- stage 1: transition minimisation ----------------
  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] qm_next;

  logic [8:0] qm1;
  logic       ve1;
  logic [1:0] ctrl1;

  // Choose XOR or XNOR chain from the byte's ones count and build qm.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    qm_next  = '0;
    n1d      = popcount8(i_data);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !i_data[0]);
    qm_next[0] = i_data[0];
    for (int i = 1; i < 8; i++) begin
      qm_next[i] = use_xnor ? ~(i_data[i] ^ qm_next[i-1]) : (i_data[i] ^ qm_next[i-1]);
    end
    qm_next[8] = ~use_xnor;
  end

  // Stage-1 register; qm only loads during data periods so a floating
  // i_data in blanking never reaches the balancing stage.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so both stages see pre-edge values.
    if (i_rst) begin
      qm1   <= '0;
      ve1   <= 1'b0;
      ctrl1 <= 2'b00;
    end else begin
      ve1   <= i_ve;
      ctrl1 <= i_ctrl;
      if (i_ve) qm1 <= qm_next;
    end
  end

  // ---------------- stage 2: DC balance ----------------
  logic [3:0]              n1;
  logic [3:0]              n0;
  logic signed [CNT_W-1:0] n1_ext;
  logic signed [CNT_W-1:0] n0_ext;
  logic signed [CNT_W-1:0] d10;      // N1 - N0
  logic signed [CNT_W-1:0] d01;      // N0 - N1
  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_next;
  logic [9:0]              tmds_next;
  logic                    cnt_pos;
  logic                    cnt_neg;

  // Pick token or balanced data symbol and the disparity it leaves behind.
  always_comb begin
    tmds_next = TOKEN_00;
    cnt_next  = ZERO;
    n1        = popcount8(qm1[7:0]);
    n0        = 4'd8 - n1;
    n1_ext    = signed'({{(CNT_W-4){1'b0}}, n1});
    n0_ext    = signed'({{(CNT_W-4){1'b0}}, n0});
    d10       = n1_ext - n0_ext;
    d01       = n0_ext - n1_ext;
    cnt_neg   = cnt[CNT_W-1];
    cnt_pos   = !cnt[CNT_W-1] && (cnt != ZERO);
    if (!ve1) begin
      // Control period: emit token and restart balancing from zero.
      case (ctrl1)
        2'b00:   tmds_next = TOKEN_00;
        2'b01:   tmds_next = TOKEN_01;
        2'b10:   tmds_next = TOKEN_10;
        default: tmds_next = TOKEN_11;
      endcase
      cnt_next = ZERO;
    end else if ((cnt == ZERO) || (n1 == n0)) begin
      tmds_next = {~qm1[8], qm1[8], qm1[8] ? qm1[7:0] : ~qm1[7:0]};
      cnt_next  = cnt + (qm1[8] ? d10 : d01);
    end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
      tmds_next = {1'b1, qm1[8], ~qm1[7:0]};
      cnt_next  = cnt + (qm1[8] ? TWO : ZERO) + d01;
    end else begin
      tmds_next = {1'b0, qm1[8], qm1[7:0]};
      cnt_next  = cnt - (qm1[8] ? ZERO : TWO) + d10;
    end
  end

  // Output symbol and running disparity update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tmds <= TOKEN_00;
      cnt    <= ZERO;
    end else begin
      o_tmds <= tmds_next;
      cnt    <= cnt_next;
    end
  end

  assign o_disparity = cnt;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Self-checking bench for tmds_channel_encoder: directed reset/token/balance
// sequences plus randomized traffic against a behavioural DVI encoder model.
module tb_tmds_channel_encoder;

  localparam int CNT_W = 5;

  logic             clk;
  logic             rst;
  logic             ve;
  logic [7:0]       data;
  logic [1:0]       ctrl;
  logic [9:0]       tmds;
  logic [CNT_W-1:0] disp;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what the encoder currently holds awaiting balancing, and
  // the running disparity as a plain integer.
  bit       m_ve   = 1'b0;
  bit [7:0] m_data = 8'h00;
  bit [1:0] m_ctrl = 2'b00;
  int       m_cnt  = 0;

  tmds_channel_encoder #(.CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ve        (ve),
    .i_data      (data),
    .i_ctrl      (ctrl),
    .o_tmds      (tmds),
    .o_disparity (disp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int disp_int();
    return int'($signed(disp));
  endfunction

  // DVI 1.0 data encoding with integer disparity bookkeeping.
  function automatic bit [9:0] model_data(input bit [7:0] d, inout int cnt);
    bit [8:0] q;
    int n1d, n1, n0;
    bit xnor_path;
    n1d = $countones(d);
    xnor_path = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xnor_path ? ~(d[i] ^ q[i-1]) : (d[i] ^ q[i-1]);
    q[8] = !xnor_path;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      cnt += q[8] ? (n1 - n0) : (n0 - n1);
      return {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      cnt += 2 * int'(q[8]) + (n0 - n1);
      return {1'b1, q[8], ~q[7:0]};
    end else begin
      cnt += -2 * int'(!q[8]) + (n1 - n0);
      return {1'b0, q[8], q[7:0]};
    end
  endfunction

  function automatic bit [9:0] model_token(input bit [1:0] c);
    bit [9:0] tok [4];
    tok[0] = 10'h354; tok[1] = 10'h0AB; tok[2] = 10'h154; tok[3] = 10'h2AB;
    return tok[c];
  endfunction

  // Recover the byte from a data symbol by undoing inversion and the chain.
  function automatic bit [7:0] decode(input bit [9:0] s);
    bit [7:0] low, d;
    low = s[9] ? ~s[7:0] : s[7:0];
    d[0] = low[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (low[i] ^ low[i-1]) : ~(low[i] ^ low[i-1]);
    return d;
  endfunction

  // One clock: drive inputs, clock, then compare the DUT against the model.
  task automatic cycle(input bit r, input bit v, input bit [7:0] d, input bit [1:0] c);
    bit [9:0] exp_sym;
    @(negedge clk);
    rst = r; ve = v; data = d; ctrl = c;
    @(posedge clk);
    #1;
    if (r) begin
      exp_sym = 10'h354;
      m_cnt = 0;
      m_ve = 1'b0; m_data = 8'h00; m_ctrl = 2'b00;
    end else begin
      if (m_ve) begin
        exp_sym = model_data(m_data, m_cnt);
        check("decode", int'(decode(tmds)), int'(m_data));
      end else begin
        exp_sym = model_token(m_ctrl);
        m_cnt = 0;
      end
      m_ve = v; m_data = d; m_ctrl = c;
    end
    check("tmds", int'(tmds), int'(exp_sym));
    check("disparity", disp_int(), m_cnt);
    check("disp_bound", int'(disp_int() <= 8 && disp_int() >= -8), 1);
  endtask

  task automatic expect_out(input string tag, input bit [9:0] sym, input int d);
    check({tag, "_tmds"}, int'(tmds), int'(sym));
    check({tag, "_disp"}, disp_int(), d);
  endtask

  initial begin
    rst = 1'b1; ve = 1'b0; data = 8'h00; ctrl = 2'b00;

    // Reset held for three cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'($urandom), 8'($urandom), 2'($urandom));
      expect_out("reset", 10'h354, 0);
    end

    // Control tokens back-to-back.
    cycle(1'b0, 1'b0, 8'h00, 2'b00);
    cycle(1'b0, 1'b0, 8'h00, 2'b01); expect_out("tok00", 10'h354, 0);
    cycle(1'b0, 1'b0, 8'h00, 2'b10); expect_out("tok01", 10'h0AB, 0);
    cycle(1'b0, 1'b0, 8'h00, 2'b11); expect_out("tok10", 10'h154, 0);
    cycle(1'b0, 1'b0, 8'h00, 2'b00); expect_out("tok11", 10'h2AB, 0);

    // Constant 0x00 stream starting from zero disparity.
    cycle(1'b0, 1'b1, 8'h00, 2'b00);
    cycle(1'b0, 1'b1, 8'h00, 2'b00); expect_out("zero0", 10'h100, -8);
    cycle(1'b0, 1'b1, 8'h00, 2'b00); expect_out("zero1", 10'h3FF, 2);
    cycle(1'b0, 1'b1, 8'h00, 2'b00); expect_out("zero2", 10'h100, -6);
    cycle(1'b0, 1'b1, 8'h00, 2'b00); expect_out("zero3", 10'h3FF, 4);

    // Reset mid-stream flushes both stages, then the stream restarts.
    cycle(1'b1, 1'b1, 8'h00, 2'b00); expect_out("mrst0", 10'h354, 0);
    cycle(1'b0, 1'b1, 8'h00, 2'b00); expect_out("mrst1", 10'h354, 0);
    cycle(1'b0, 1'b1, 8'h00, 2'b00); expect_out("mrst2", 10'h100, -8);

    // Single control cycle between data clears the disparity.
    cycle(1'b1, 1'b0, 8'h00, 2'b00);
    cycle(1'b0, 1'b1, 8'h00, 2'b00);
    cycle(1'b0, 1'b0, 8'h00, 2'b00); expect_out("tog0", 10'h100, -8);
    cycle(1'b0, 1'b1, 8'h00, 2'b00); expect_out("tog1", 10'h354, 0);
    cycle(1'b0, 1'b1, 8'h00, 2'b00); expect_out("tog2", 10'h100, -8);

    // Randomized traffic: mostly data, frequent blanking, rare resets.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom), 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
